// File: rtl/qla_spi_pkg.sv
// rtl/qla_spi_pkg.sv - opcode, FSM state and status-bit definitions for the SPI command decoder
package qla_spi_pkg;

  typedef enum logic [7:0] {
    OP_WR_W  = 8'h01,
    OP_WR_A  = 8'h02,
    OP_START = 8'h03,
    OP_CLR   = 8'h04
  } opcode_e;

  typedef enum logic [2:0] {
    OPC,
    ADDR_H,
    ADDR_L,
    LEN_H,
    LEN_L,
    PAYLOAD,
    CSUM
  } cmd_state_e;

  localparam int ST_BAD_OP    = 0;
  localparam int ST_ABORT     = 1;
  localparam int ST_START_ERR = 2;
  localparam int ST_CSUM_ERR  = 3;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// rtl/spi_cmd_decoder_if.sv - buffer write port between the command decoder and the W/A buffers
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 10
);
  logic              wr_en;
  logic              wr_buf;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, output wr_buf, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_buf, input  wr_addr, input  wr_data);
endinterface

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI byte stream to buffer-write/start command decoder
// Optional trailing XOR checksum per write packet when SPI_CMD_CSUM_EN is defined.
module spi_cmd_decoder
  import qla_spi_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  input  logic                      frame_active,
  input  logic                      core_busy,
  input  logic                      status_clr,
  spi_cmd_decoder_if.master         wr_bus,
  output logic                      start,
  output logic                      in_packet,
  output logic [3:0]                status
);

`ifdef SPI_CMD_CSUM_EN
  localparam cmd_state_e DONE_ST = CSUM;
`else
  localparam cmd_state_e DONE_ST = OPC;
`endif

  cmd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              buf_q, buf_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_buf_q, wr_buf_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic [3:0]        status_q, status_d;
  logic [3:0]        set;
  logic              clr;
  logic              byte_ok;
`ifdef SPI_CMD_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_hi_d = addr_hi_q;
    len_d     = len_q;
    buf_d     = buf_q;
    wr_en_d   = 1'b0;
    wr_buf_d  = wr_buf_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    set       = 4'b0000;
    clr       = status_clr;
    byte_ok   = rx_valid && frame_active;
`ifdef SPI_CMD_CSUM_EN
    csum_d    = csum_q;
    if (byte_ok) csum_d = (state_q == OPC) ? rx_byte : (csum_q ^ rx_byte);
`endif

    // CS released mid-packet takes priority over any byte arriving that cycle
    if (!frame_active && state_q != OPC) begin
      state_d       = OPC;
      set[ST_ABORT] = 1'b1;
    end else if (byte_ok) begin
      case (state_q)
        OPC: begin
          case (rx_byte)
            OP_WR_W, OP_WR_A: begin
              buf_d   = (rx_byte == OP_WR_A);
              state_d = ADDR_H;
            end
            OP_START: begin
              if (core_busy) set[ST_START_ERR] = 1'b1;
              else           start_d = 1'b1;
            end
            OP_CLR:  clr = 1'b1;
            default: set[ST_BAD_OP] = 1'b1;
          endcase
        end
        ADDR_H: begin
          addr_hi_d = rx_byte;
          state_d   = ADDR_L;
        end
        ADDR_L: begin
          ptr_d   = ADDR_W'({addr_hi_q, rx_byte});
          state_d = LEN_H;
        end
        LEN_H: begin
          len_d   = LEN_W'({rx_byte, 8'h00});
          state_d = LEN_L;
        end
        LEN_L: begin
          len_d   = len_q | LEN_W'(rx_byte);
          state_d = (len_d == '0) ? DONE_ST : PAYLOAD;
        end
        PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_buf_d  = buf_q;
          wr_addr_d = ptr_q;
          wr_data_d = rx_byte;
          ptr_d     = ptr_q + ADDR_W'(1);
          len_d     = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state_d = DONE_ST;
        end
`ifdef SPI_CMD_CSUM_EN
        CSUM: begin
          if (rx_byte != csum_q) set[ST_CSUM_ERR] = 1'b1;
          state_d = OPC;
        end
`endif
        default: state_d = OPC;
      endcase
    end

    status_d = (clr ? 4'b0000 : status_q) | set;
`ifndef SPI_CMD_CSUM_EN
    status_d[ST_CSUM_ERR] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OPC;
      ptr_q     <= '0;
      addr_hi_q <= '0;
      len_q     <= '0;
      buf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_buf_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      status_q  <= '0;
`ifdef SPI_CMD_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_hi_q <= addr_hi_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      wr_en_q   <= wr_en_d;
      wr_buf_q  <= wr_buf_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      status_q  <= status_d;
`ifdef SPI_CMD_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign wr_bus.wr_en   = wr_en_q;
  assign wr_bus.wr_buf  = wr_buf_q;
  assign wr_bus.wr_addr = wr_addr_q;
  assign wr_bus.wr_data = wr_data_q;
  assign start          = start_q;
  assign in_packet      = (state_q != OPC);
  assign status         = status_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - directed-vector self-checking bench for spi_cmd_decoder
module tb_spi_cmd_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_active;
  logic       core_busy;
  logic       status_clr;
  logic       start;
  logic       in_packet;
  logic [3:0] status;

  int n_vec   = 0;
  int n_bad   = 0;
  int n_start = 0;
  logic [18:0] wq[$];

  spi_cmd_decoder_if #(.ADDR_W(10)) wr_bus ();

  spi_cmd_decoder #(.ADDR_W(10), .LEN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .frame_active (frame_active),
    .core_busy    (core_busy),
    .status_clr   (status_clr),
    .wr_bus       (wr_bus),
    .start        (start),
    .in_packet    (in_packet),
    .status       (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_bus.wr_en) wq.push_back({wr_bus.wr_buf, wr_bus.wr_addr, wr_bus.wr_data});
    if (start) n_start++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_wr(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data[$]);
    logic [7:0]  x;
    logic [15:0] len;
    len = 16'(data.size());
    x   = op ^ addr[15:8] ^ addr[7:0] ^ len[15:8] ^ len[7:0];
    send_byte(op);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    foreach (data[i]) begin
      send_byte(data[i]);
      x = x ^ data[i];
    end
`ifdef SPI_CMD_CSUM_EN
    send_byte(x);
`endif
    settle();
  endtask

  task automatic expect_wr(input string tag, input logic b, input logic [9:0] a, input logic [7:0] d);
    logic [18:0] got;
    got = '1;
    if (wq.size() > 0) got = wq.pop_front();
    check(tag, 32'(got), 32'({b, a, d}));
  endtask

  initial begin
    logic [7:0] d[$];
    rst_n        = 1'b1;
    rx_byte      = 8'h00;
    rx_valid     = 1'b0;
    frame_active = 1'b0;
    core_busy    = 1'b0;
    status_clr   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en", wr_bus.wr_en, 0);
    check("rst_wr_buf", wr_bus.wr_buf, 0);
    check("rst_wr_addr", wr_bus.wr_addr, 0);
    check("rst_wr_data", wr_bus.wr_data, 0);
    check("rst_start", start, 0);
    check("rst_in_packet", in_packet, 0);
    check("rst_status", status, 0);
    rst_n        = 1'b1;
    frame_active = 1'b1;

    d = '{8'hAA, 8'hBB, 8'hCC};
    send_wr(8'h01, 16'h0005, d);
    check("t1_count", wq.size(), 3);
    expect_wr("t1_w0", 1'b0, 10'h005, 8'hAA);
    expect_wr("t1_w1", 1'b0, 10'h006, 8'hBB);
    expect_wr("t1_w2", 1'b0, 10'h007, 8'hCC);
    check("t1_status", status, 0);
    check("t1_in_packet", in_packet, 0);

    d = '{8'h11, 8'h22};
    send_wr(8'h02, 16'h03FF, d);
    check("t2_count", wq.size(), 2);
    expect_wr("t2_w0", 1'b1, 10'h3FF, 8'h11);
    expect_wr("t2_wrap", 1'b1, 10'h000, 8'h22);

    d = '{8'h5C};
    send_wr(8'h01, 16'hFC10, d);
    expect_wr("trunc_addr", 1'b0, 10'h010, 8'h5C);

    d.delete();
    send_wr(8'h01, 16'h0100, d);
    check("zero_len_count", wq.size(), 0);
    check("zero_len_in_packet", in_packet, 0);

    send_byte(8'h7E);
    check("t3_bad_op", status, 4'b0001);
    check("t3_in_packet", in_packet, 0);
    n_start = 0;
    send_byte(8'h03);
    check("t3_start_hi", start, 1);
    settle();
    check("t3_start_lo", start, 0);
    check("t3_start_count", n_start, 1);

    core_busy = 1'b1;
    send_byte(8'h03);
    check("t4_no_start", start, 0);
    settle();
    check("t4_start_err", status, 4'b0101);
    check("t4_start_count", n_start, 1);
    core_busy = 1'b0;
    send_byte(8'h04);
    check("t4_clr_op", status, 4'b0000);

    @(negedge clk);
    rx_byte    = 8'h7E;
    rx_valid   = 1'b1;
    status_clr = 1'b1;
    @(negedge clk);
    rx_valid   = 1'b0;
    status_clr = 1'b0;
    check("set_beats_clr", status, 4'b0001);
    @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    check("status_clr_pin", status, 4'b0000);

    frame_active = 1'b0;
    send_byte(8'h7E);
    check("ignored_no_frame", status, 4'b0000);
    frame_active = 1'b1;

    send_byte(8'h01);
    check("t5_in_packet", in_packet, 1);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hD1);
    send_byte(8'hD2);
    frame_active = 1'b0;
    settle();
    check("t5_abort_in_packet", in_packet, 0);
    check("t5_abort_status", status, 4'b0010);
    check("t5_count", wq.size(), 2);
    expect_wr("t5_w0", 1'b0, 10'h010, 8'hD1);
    expect_wr("t5_w1", 1'b0, 10'h011, 8'hD2);
    frame_active = 1'b1;
    d = '{8'hE7};
    send_wr(8'h01, 16'h0020, d);
    expect_wr("t5_next_frame", 1'b0, 10'h020, 8'hE7);
    check("t5_sticky", status, 4'b0010);

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    @(negedge clk);
    rx_byte  = 8'h33;
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_packet", in_packet, 0);
    check("mid_rst_status", status, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("mid_rst_wr_en", wr_bus.wr_en, 0);
    check("mid_rst_no_write", wq.size(), 0);
    rst_n = 1'b1;
    d = '{8'h9C};
    send_wr(8'h02, 16'h0001, d);
    expect_wr("post_rst_write", 1'b1, 10'h001, 8'h9C);

`ifdef SPI_CMD_CSUM_EN
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h5A);
    settle();
    expect_wr("t6_good_write", 1'b0, 10'h000, 8'h5A);
    check("t6_good_status", status, 4'b0000);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h00);
    settle();
    expect_wr("t6_bad_write", 1'b0, 10'h000, 8'h5A);
    check("t6_bad_status", status, 4'b1000);
    check("t6_in_packet", in_packet, 0);
`endif

    check("final_no_stray_writes", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
